// File: rtl/lsq_mem_pkg.sv
// lsq_mem_pkg: shared memory-op type and channel-id width helper for the LSQ memory arbiter.
package lsq_mem_pkg;
  typedef enum logic {
    MEM_OP_LOAD  = 1'b0,
    MEM_OP_STORE = 1'b1
  } memory_op_t;

  // Never narrower than one bit, so a single channel still gets a legal id.
  function automatic int ch_id_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction
endpackage

// File: rtl/lsq_arb_id_fifo.sv
// lsq_arb_id_fifo: synchronous FIFO of channel ids recording the issue order of in-flight requests.
module lsq_arb_id_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             din_i,
  output logic [W-1:0]             dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q;

  assign dout_o  = mem_q[rd_q];
  assign full_o  = count_q == CW'(DEPTH);
  assign empty_o = count_q == '0;
  assign count_o = count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i) rd_q <= rd_q + 1'b1;
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk)
    if (push_i) mem_q[wr_q] <= din_i;
endmodule

// File: rtl/lsq_mem_ctrl_arb.sv
// lsq_mem_ctrl_arb: round-robin arbiter of NUM_CH LSQ channels onto one memory port, routing in-order responses back.
// Define LSQ_MEM_ARB_FIXED_PRIO_EN for fixed priority (lowest channel index wins).
`ifndef D_MEMORY_ADDR_WIDTH
`define D_MEMORY_ADDR_WIDTH 32
`endif
`ifndef REG_VAL_WIDTH
`define REG_VAL_WIDTH 32
`endif
module lsq_mem_ctrl_arb
  import lsq_mem_pkg::*;
#(
  parameter int NUM_CH          = 2,
  parameter int ADDR_W          = `D_MEMORY_ADDR_WIDTH,
  parameter int DATA_W          = `REG_VAL_WIDTH,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic       [NUM_CH-1:0]             lsq_req_valid,
  input  memory_op_t [NUM_CH-1:0]             lsq_req_op,
  input  logic       [NUM_CH-1:0][ADDR_W-1:0] lsq_req_address,
  input  logic       [NUM_CH-1:0][DATA_W-1:0] lsq_req_data,
  output logic       [NUM_CH-1:0]             lsq_ready,
  output logic       [NUM_CH-1:0]             lsq_done,
  output logic       [DATA_W-1:0]             lsq_data,
  output logic                                mem_req_valid,
  output memory_op_t                          mem_req_op,
  output logic       [ADDR_W-1:0]             mem_req_address,
  output logic       [DATA_W-1:0]             mem_req_data,
  input  logic                                mem_req_ready,
  input  logic                                mem_resp_valid,
  input  logic       [DATA_W-1:0]             mem_resp_data,
  output logic                                resp_underflow_err
);
  localparam int IW = ch_id_w(NUM_CH);
  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

  logic [IW-1:0]     start_ptr, grant_id, head_id, idx;
  logic              grant_any, or_free, pop, slot_avail, accept, fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic              mem_req_valid_q, err_q;
  memory_op_t        mem_req_op_q;
  logic [ADDR_W-1:0] mem_req_address_q;
  logic [DATA_W-1:0] mem_req_data_q, lsq_data_q;
  logic [NUM_CH-1:0] lsq_done_q;

  assign or_free    = !mem_req_valid_q || mem_req_ready;
  assign pop        = mem_resp_valid && !fifo_empty;
  assign slot_avail = !fifo_full || pop;
  assign accept     = grant_any && or_free && slot_avail;
  assign lsq_ready  = (!reset && accept) ? NUM_CH'(1) << grant_id : '0;

  assign mem_req_valid      = mem_req_valid_q;
  assign mem_req_op         = mem_req_op_q;
  assign mem_req_address    = mem_req_address_q;
  assign mem_req_data       = mem_req_data_q;
  assign lsq_done           = lsq_done_q;
  assign lsq_data           = lsq_data_q;
  assign resp_underflow_err = err_q;

`ifdef LSQ_MEM_ARB_FIXED_PRIO_EN
  assign start_ptr = '0;
`else
  logic [IW-1:0] rr_ptr_q;
  assign start_ptr = rr_ptr_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rr_ptr_q <= '0;
    else if (accept) rr_ptr_q <= IW'((int'(grant_id) + 1) % NUM_CH);
  end
`endif

  // Scan from the farthest candidate back toward start_ptr so the nearest valid channel wins.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    idx       = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = IW'((int'(start_ptr) + i) % NUM_CH);
      if (lsq_req_valid[idx]) begin
        grant_any = 1'b1;
        grant_id  = idx;
      end
    end
  end

  lsq_arb_id_fifo #(.DEPTH(MAX_OUTSTANDING), .W(IW)) u_fifo (
    .clk(clk), .rst(reset), .push_i(accept), .pop_i(pop), .din_i(grant_id),
    .dout_o(head_id), .full_o(fifo_full), .empty_o(fifo_empty), .count_o(fifo_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req_valid_q   <= 1'b0;
      mem_req_op_q      <= MEM_OP_LOAD;
      mem_req_address_q <= '0;
      mem_req_data_q    <= '0;
      lsq_done_q        <= '0;
      lsq_data_q        <= '0;
      err_q             <= 1'b0;
    end else begin
      if (accept) begin
        mem_req_valid_q   <= 1'b1;
        mem_req_op_q      <= lsq_req_op[grant_id];
        mem_req_address_q <= lsq_req_address[grant_id];
        mem_req_data_q    <= lsq_req_data[grant_id];
      end else if (mem_req_ready) begin
        mem_req_valid_q <= 1'b0;
      end
      lsq_done_q <= pop ? NUM_CH'(1) << head_id : '0;
      if (pop) lsq_data_q <= mem_resp_data;
      if (mem_resp_valid && fifo_empty) err_q <= 1'b1;
    end
  end

  a_count_bound: assert property (@(posedge clk) disable iff (reset) fifo_count <= CW'(MAX_OUTSTANDING));
endmodule

// File: tb/tb_lsq_mem_ctrl_arb.sv
// tb_lsq_mem_ctrl_arb: directed vector table plus randomized traffic checked against a queue-based model.
`ifndef D_MEMORY_ADDR_WIDTH
`define D_MEMORY_ADDR_WIDTH 32
`endif
`ifndef REG_VAL_WIDTH
`define REG_VAL_WIDTH 32
`endif
module tb_lsq_mem_ctrl_arb;
  import lsq_mem_pkg::*;
  localparam int N = 2, AW = `D_MEMORY_ADDR_WIDTH, DW = `REG_VAL_WIDTH, MAXO = 4;
`ifdef LSQ_MEM_ARB_FIXED_PRIO_EN
  localparam bit FP = 1'b1;
`else
  localparam bit FP = 1'b0;
`endif

  logic clk, reset;
  logic       [N-1:0]         lsq_req_valid, lsq_ready, lsq_done;
  memory_op_t [N-1:0]         lsq_req_op;
  logic       [N-1:0][AW-1:0] lsq_req_address;
  logic       [N-1:0][DW-1:0] lsq_req_data;
  logic       [DW-1:0]        lsq_data, mem_req_data, mem_resp_data;
  logic                       mem_req_valid, mem_req_ready, mem_resp_valid, resp_underflow_err;
  memory_op_t                 mem_req_op;
  logic       [AW-1:0]        mem_req_address;

  lsq_mem_ctrl_arb #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .reset(reset), .lsq_req_valid(lsq_req_valid), .lsq_req_op(lsq_req_op),
    .lsq_req_address(lsq_req_address), .lsq_req_data(lsq_req_data), .lsq_ready(lsq_ready),
    .lsq_done(lsq_done), .lsq_data(lsq_data), .mem_req_valid(mem_req_valid), .mem_req_op(mem_req_op),
    .mem_req_address(mem_req_address), .mem_req_data(mem_req_data), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .resp_underflow_err(resp_underflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] v, op;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;
    logic mr, rv;
    logic [DW-1:0] rd;
    logic [1:0] e_rdy;
    logic e_mv;
    logic [AW-1:0] e_ma;
    logic [1:0] e_done;
    logic [DW-1:0] e_ld;
    logic e_err;
  } vec_t;

  int checks = 0, fails = 0;
  bit m_orv, m_err;
  logic m_oro;
  logic [AW-1:0] m_ora;
  logic [DW-1:0] m_ord, m_ld;
  logic [N-1:0] m_done;
  int q[$];
  int m_rr;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] v, input logic [AW-1:0] a0, a1, input logic mr, rv,
                              input logic [DW-1:0] rd, input logic [1:0] e_rdy, input logic e_mv,
                              input logic [AW-1:0] e_ma, input logic [1:0] e_done,
                              input logic [DW-1:0] e_ld, input logic e_err);
    vec_t r;
    r.v = v; r.op = 2'b10; r.a0 = a0; r.a1 = a1;
    r.d0 = DW'(a0) ^ 'h5a5a; r.d1 = DW'(a1) ^ 'ha5a5;
    r.mr = mr; r.rv = rv; r.rd = rd;
    r.e_rdy = e_rdy; r.e_mv = e_mv; r.e_ma = e_ma; r.e_done = e_done; r.e_ld = e_ld; r.e_err = e_err;
    return r;
  endfunction

  task automatic model_reset();
    m_orv = 0; m_err = 0; m_oro = 0; m_ora = '0; m_ord = '0; m_ld = '0; m_done = '0; m_rr = 0;
    q.delete();
  endtask

  task automatic step(input vec_t t, input bit use_exp);
    int g;
    bit pop, acc;
    logic [N-1:0] rdy;
    @(posedge clk); #1;
    lsq_req_valid = t.v;
    lsq_req_op[0] = memory_op_t'(t.op[0]);
    lsq_req_op[1] = memory_op_t'(t.op[1]);
    lsq_req_address = {t.a1, t.a0};
    lsq_req_data = {t.d1, t.d0};
    mem_req_ready = t.mr;
    mem_resp_valid = t.rv;
    mem_resp_data = t.rd;
    #1;
    pop = t.rv && q.size() > 0;
    g = -1;
    for (int k = 0; k < N; k++)
      if (g < 0 && t.v[(m_rr + k) % N]) g = (m_rr + k) % N;
    acc = g >= 0 && (!m_orv || t.mr) && (q.size() < MAXO || pop);
    rdy = acc ? N'(1) << g : '0;
    chk("lsq_ready", 64'(lsq_ready), 64'(rdy));
    chk("mem_req_valid", 64'(mem_req_valid), 64'(m_orv));
    if (m_orv) begin
      chk("mem_req_address", 64'(mem_req_address), 64'(m_ora));
      chk("mem_req_data", 64'(mem_req_data), 64'(m_ord));
      chk("mem_req_op", 64'(mem_req_op), 64'(m_oro));
    end
    chk("lsq_done", 64'(lsq_done), 64'(m_done));
    chk("lsq_data", 64'(lsq_data), 64'(m_ld));
    chk("resp_underflow_err", 64'(resp_underflow_err), 64'(m_err));
    if (use_exp) begin
      chk("tbl_ready", 64'(lsq_ready), 64'(t.e_rdy));
      chk("tbl_mvalid", 64'(mem_req_valid), 64'(t.e_mv));
      if (t.e_mv) chk("tbl_maddr", 64'(mem_req_address), 64'(t.e_ma));
      chk("tbl_done", 64'(lsq_done), 64'(t.e_done));
      chk("tbl_data", 64'(lsq_data), 64'(t.e_ld));
      chk("tbl_err", 64'(resp_underflow_err), 64'(t.e_err));
    end
    if (t.rv && q.size() == 0) m_err = 1;
    m_done = pop ? N'(1) << q[0] : '0;
    if (pop) begin
      m_ld = t.rd;
      void'(q.pop_front());
    end
    if (acc) begin
      q.push_back(g);
      m_orv = 1;
      m_ora = g ? t.a1 : t.a0;
      m_ord = g ? t.d1 : t.d0;
      m_oro = t.op[g];
      if (!FP) m_rr = (g + 1) % N;
    end else if (t.mr) m_orv = 0;
  endtask

  task automatic chk_reset_zero();
    chk("rst_ready", 64'(lsq_ready), 0);
    chk("rst_mvalid", 64'(mem_req_valid), 0);
    chk("rst_mop", 64'(mem_req_op), 0);
    chk("rst_maddr", 64'(mem_req_address), 0);
    chk("rst_mdata", 64'(mem_req_data), 0);
    chk("rst_done", 64'(lsq_done), 0);
    chk("rst_data", 64'(lsq_data), 0);
    chk("rst_err", 64'(resp_underflow_err), 0);
  endtask

  task automatic idle_inputs();
    lsq_req_valid = '0; lsq_req_op = '{MEM_OP_LOAD, MEM_OP_LOAD}; lsq_req_address = '0; lsq_req_data = '0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = '0;
  endtask

  vec_t tbl[35];
  vec_t r;

  initial begin
    tbl[0]  = mk(2'b01, 'h40, 0, 1, 0, 0, 2'b01, 0, 0, 2'b00, 0, 0);
    tbl[1]  = mk(2'b00, 0, 0, 1, 0, 0, 2'b00, 1, 'h40, 2'b00, 0, 0);
    tbl[2]  = mk(2'b00, 0, 0, 1, 1, 'hDEAD, 2'b00, 0, 0, 2'b00, 0, 0);
    tbl[3]  = mk(2'b00, 0, 0, 1, 0, 0, 2'b00, 0, 0, 2'b01, 'hDEAD, 0);
    tbl[4]  = mk(2'b00, 0, 0, 1, 0, 0, 2'b00, 0, 0, 2'b00, 'hDEAD, 0);
    tbl[5]  = mk(2'b10, 0, 'h100, 1, 0, 0, 2'b10, 0, 0, 2'b00, 'hDEAD, 0);
    tbl[6]  = mk(2'b01, 'h200, 0, 1, 0, 0, 2'b01, 1, 'h100, 2'b00, 'hDEAD, 0);
    tbl[7]  = mk(2'b10, 0, 'h300, 1, 0, 0, 2'b10, 1, 'h200, 2'b00, 'hDEAD, 0);
    tbl[8]  = mk(2'b00, 0, 0, 1, 1, 1, 2'b00, 1, 'h300, 2'b00, 'hDEAD, 0);
    tbl[9]  = mk(2'b00, 0, 0, 1, 1, 2, 2'b00, 0, 0, 2'b10, 1, 0);
    tbl[10] = mk(2'b00, 0, 0, 1, 1, 3, 2'b00, 0, 0, 2'b01, 2, 0);
    tbl[11] = mk(2'b00, 0, 0, 1, 0, 0, 2'b00, 0, 0, 2'b10, 3, 0);
    tbl[12] = mk(2'b00, 0, 0, 1, 0, 0, 2'b00, 0, 0, 2'b00, 3, 0);
    tbl[13] = mk(2'b01, 'h500, 0, 0, 0, 0, 2'b01, 0, 0, 2'b00, 3, 0);
    tbl[14] = mk(2'b10, 0, 'h600, 0, 0, 0, 2'b00, 1, 'h500, 2'b00, 3, 0);
    tbl[15] = mk(2'b10, 0, 'h600, 0, 0, 0, 2'b00, 1, 'h500, 2'b00, 3, 0);
    tbl[16] = mk(2'b10, 0, 'h600, 1, 0, 0, 2'b10, 1, 'h500, 2'b00, 3, 0);
    tbl[17] = mk(2'b00, 0, 0, 1, 0, 0, 2'b00, 1, 'h600, 2'b00, 3, 0);
    tbl[18] = mk(2'b00, 0, 0, 1, 1, 7, 2'b00, 0, 0, 2'b00, 3, 0);
    tbl[19] = mk(2'b00, 0, 0, 1, 1, 8, 2'b00, 0, 0, 2'b01, 7, 0);
    tbl[20] = mk(2'b00, 0, 0, 1, 0, 0, 2'b00, 0, 0, 2'b10, 8, 0);
    tbl[21] = mk(2'b11, 'h10, 'h20, 1, 0, 0, 2'b01, 0, 0, 2'b00, 8, 0);
    tbl[22] = mk(2'b11, 'h10, 'h20, 1, 0, 0, FP ? 2'b01 : 2'b10, 1, 'h10, 2'b00, 8, 0);
    tbl[23] = mk(2'b11, 'h10, 'h20, 1, 0, 0, 2'b01, 1, FP ? 'h10 : 'h20, 2'b00, 8, 0);
    tbl[24] = mk(2'b11, 'h10, 'h20, 1, 0, 0, FP ? 2'b01 : 2'b10, 1, 'h10, 2'b00, 8, 0);
    tbl[25] = mk(2'b11, 'h10, 'h20, 1, 0, 0, 2'b00, 1, FP ? 'h10 : 'h20, 2'b00, 8, 0);
    tbl[26] = mk(2'b11, 'h10, 'h20, 1, 1, 'hA, 2'b01, 0, 0, 2'b00, 8, 0);
    tbl[27] = mk(2'b11, 'h10, 'h20, 1, 0, 0, 2'b00, 1, 'h10, 2'b01, 'hA, 0);
    tbl[28] = mk(2'b00, 0, 0, 1, 1, 'hB, 2'b00, 0, 0, 2'b00, 'hA, 0);
    tbl[29] = mk(2'b00, 0, 0, 1, 1, 'hC, 2'b00, 0, 0, FP ? 2'b01 : 2'b10, 'hB, 0);
    tbl[30] = mk(2'b00, 0, 0, 1, 1, 'hD, 2'b00, 0, 0, 2'b01, 'hC, 0);
    tbl[31] = mk(2'b00, 0, 0, 1, 1, 'hE, 2'b00, 0, 0, FP ? 2'b01 : 2'b10, 'hD, 0);
    tbl[32] = mk(2'b00, 0, 0, 1, 0, 0, 2'b00, 0, 0, 2'b01, 'hE, 0);
    tbl[33] = mk(2'b00, 0, 0, 1, 1, 'hF, 2'b00, 0, 0, 2'b00, 'hE, 0);
    tbl[34] = mk(2'b00, 0, 0, 1, 0, 0, 2'b00, 0, 0, 2'b00, 'hE, 1);

    idle_inputs();
    reset = 1;
    lsq_req_valid = 2'b11; mem_req_ready = 1; mem_resp_valid = 1;
    model_reset();
    #3;
    chk_reset_zero();
    @(posedge clk); #1;
    idle_inputs();
    reset = 0;

    foreach (tbl[i]) step(tbl[i], 1);

    for (int i = 0; i < 400; i++) begin
      r = mk(2'(($urandom_range(0, 3) != 0) ? $urandom : 0), $urandom, $urandom, $urandom_range(0, 3) != 0,
             $urandom_range(0, 2) == 0, $urandom, 0, 0, 0, 0, 0, 0);
      r.op = 2'($urandom);
      r.d0 = $urandom;
      r.d1 = $urandom;
      step(r, 0);
    end

    @(posedge clk); #1;
    lsq_req_valid = 2'b11; mem_req_ready = 1; mem_resp_valid = 1;
    reset = 1;
    #1;
    chk_reset_zero();
    @(posedge clk); #1;
    idle_inputs();
    reset = 0;
    model_reset();
    step(mk(2'b01, 'h40, 0, 1, 0, 0, 2'b01, 0, 0, 2'b00, 0, 0), 1);
    step(mk(2'b00, 0, 0, 1, 1, 'h1234, 2'b00, 1, 'h40, 2'b00, 0, 0), 1);
    step(mk(2'b00, 0, 0, 1, 0, 0, 2'b00, 0, 0, 2'b01, 'h1234, 0), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/lsq_mem_ctrl_arb.md
Name: lsq_mem_ctrl_arb

Overview:
- Multi-channel successor to the single LSQ-to-memory-controller handshake.
- Arbitrates NUM_CH independent LSQ request channels onto one memory-controller request port, round-robin.
- Keeps up to MAX_OUTSTANDING in-flight requests in an ordered tracking FIFO and routes each in-order memory response back to the channel that issued it.
- Sits between the load/store queue(s) and the data-memory controller.

Parameters:
- NUM_CH, 2, number of LSQ request channels (>=1).
- ADDR_W, `D_MEMORY_ADDR_WIDTH, request address width.
- DATA_W, `REG_VAL_WIDTH, store/load data width.
- MAX_OUTSTANDING, 4, tracking FIFO depth (power of 2, >=2).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-high reset.
- lsq_req_valid  in  NUM_CH  per-channel request valid.
- lsq_req_op  in  NUM_CH x memory_op_t  per-channel load/store op.
- lsq_req_address  in  NUM_CH x ADDR_W  per-channel address.
- lsq_req_data  in  NUM_CH x DATA_W  per-channel store data.
- lsq_ready  out  NUM_CH  per-channel accept (combinational).
- lsq_done  out  NUM_CH  one-cycle completion pulse, registered.
- lsq_data  out  DATA_W  response data, valid with any lsq_done.
- mem_req_valid  out  1  request to memory controller, registered.
- mem_req_op  out  memory_op_t  op.
- mem_req_address  out  ADDR_W  address.
- mem_req_data  out  DATA_W  data.
- mem_req_ready  in  1  memory controller accepts the request.
- mem_resp_valid  in  1  in-order completion from the memory controller, one per request.
- mem_resp_data  in  DATA_W  load data (ignored for stores).
- resp_underflow_err  out  1  sticky error flag.

Behaviour:
- Reset (async, active-high): all outputs 0, rr_ptr=0, FIFO empty (count=0), output register empty.
- Output register (OR): holds one request.
  - OR is free when !mem_req_valid, or mem_req_valid && mem_req_ready in the same cycle.
- Slot available: count<MAX_OUTSTANDING, or a response pops in the same cycle.
- can_accept = OR free && slot available.
- Arbitration is combinational over lsq_req_valid, starting at rr_ptr and wrapping modulo NUM_CH. The first valid channel g wins.
  - lsq_ready[g] = can_accept. All other lsq_ready bits are 0.
  - lsq_ready does not depend on lsq_req_valid[g] beyond the winner selection.
- Accept (valid && ready on channel g):
  - Next cycle: mem_req_valid=1 and op/address/data load from channel g.
  - Channel id g is pushed into the FIFO and count is incremented.
  - rr_ptr becomes (g+1) mod NUM_CH. It is unchanged when nothing is accepted.
- mem_req_* hold stable while mem_req_valid && !mem_req_ready.
  - mem_req_valid drops the cycle after handshake unless a new accept occurs.
- Latency: accept to mem_req_valid is 1 cycle. Max throughput is 1 request/cycle while mem_req_ready=1 and slots are free.
- Response handling, on mem_resp_valid with FIFO non-empty:
  - FIFO head h is popped and count is decremented.
  - Next cycle: lsq_done[h]=1 for exactly one cycle and lsq_data=mem_resp_data.
  - lsq_data holds its last value otherwise.
  - Stores also receive lsq_done.
- Simultaneous push and pop: count is unchanged and both take effect. A push into a full FIFO is legal only with a same-cycle pop.
- Response with FIFO empty: ignored (no lsq_done), resp_underflow_err is set and stays set until reset.
- Wrap-around: FIFO pointers are log2(MAX_OUTSTANDING) bits and wrap naturally. Count is log2(MAX_OUTSTANDING)+1 bits.
- NUM_CH=1: arbiter degenerates to a pass-through and rr_ptr stays 0.
- Reset mid-operation: in-flight requests and the FIFO are dropped. The LSQ and memory controller are reset by the same signal.

Optional Feature:
- Macro LSQ_MEM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest channel index wins. rr_ptr is removed and stays 0.
- Undefined: round-robin as above.
- All other behaviour is identical.

Decomposition:
- Shared package (lsq_mem_pkg): memory_op_t (MEM_OP_LOAD=0, MEM_OP_STORE=1) and a CH_ID_W = $clog2(NUM_CH) helper function.
- Address and data width defaults come from the existing global `D_MEMORY_ADDR_WIDTH / `REG_VAL_WIDTH macros.
- One sub-module: lsq_arb_id_fifo, a parametrised synchronous FIFO of channel ids with push, pop, full, empty and count.

Test Plan:
- Single channel: ch0 load addr 0x40, mem_req_ready=1 -> mem_req_valid with addr 0x40 one cycle later. Response data 0xDEAD -> lsq_done[0] pulse one cycle later, lsq_data=0xDEAD.
- Contention: ch0 and ch1 valid every cycle, NUM_CH=2 -> grants alternate 0,1,0,1, and the FIFO id order matches.
  - With LSQ_MEM_ARB_FIXED_PRIO_EN, ch0 is granted every cycle.
- Backpressure: mem_req_ready=0 for 3 cycles -> mem_req_* stable, lsq_ready=0, no extra FIFO push.
- Full FIFO: 4 accepted requests with no responses -> lsq_ready=0. Response in the same cycle as a new valid request -> accept allowed and count stays 4.
- Ordering: issue ch1,ch0,ch1, then 3 responses 0x1,0x2,0x3 -> done pulses ch1/0x1, ch0/0x2, ch1/0x3.
- Spurious response while empty -> no lsq_done, resp_underflow_err=1 until reset. Assert reset mid-stream -> all outputs 0 immediately.
